// File: rtl/flatten_stream_pkg.sv
// Shared types and widths for the flatten stage between the last conv/pool layer
// and the dense layer.
package flatten_stream_pkg;

    localparam int FEATURE_MAP_RESOLUTION = 8;
    localparam int FEATURE_MAP_ADDRWIDE   = 8;

    typedef enum logic {
        FLAT_HWC,
        FLAT_CHW
    } flatten_order_e;

    typedef enum logic {
        FILL,
        HOLD
    } flatten_state_e;

    // Counter width that stays at one bit for single-pixel frames.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flatten_stream_if.sv
// Pixel-in / flattened-vector-out handshake bundle. The slave modport is the flatten
// block; the master modport is the upstream producer plus downstream consumer.
interface flatten_stream_if
    import flatten_stream_pkg::*;
#(
    parameter int F_IN_D           = 8,
    parameter int FLATTEN_OUT_SIZE = 40
) ();

    logic                                                  feature_in_valid_i;
    logic [F_IN_D-1:0][FEATURE_MAP_RESOLUTION-1:0]         feature_in_data_i;
    logic [FEATURE_MAP_ADDRWIDE-1:0]                       feature_in_addr_i;
    logic                                                  feature_in_ready_o;
    logic                                                  flatten_valid_o;
    logic [FLATTEN_OUT_SIZE-1:0][FEATURE_MAP_RESOLUTION-1:0] flatten_data_o;
    logic                                                  flatten_ready_i;

    modport slave (
        input  feature_in_valid_i,
        input  feature_in_data_i,
        input  feature_in_addr_i,
        output feature_in_ready_o,
        output flatten_valid_o,
        output flatten_data_o,
        input  flatten_ready_i
    );

    modport master (
        output feature_in_valid_i,
        output feature_in_data_i,
        output feature_in_addr_i,
        input  feature_in_ready_o,
        input  flatten_valid_o,
        input  flatten_data_o,
        output flatten_ready_i
    );

endinterface

// File: rtl/flatten_index_gen.sv
// Maps (pixel counter, channel) to a slot of the flattened buffer for the chosen
// output ordering. Purely combinational; one instance per channel.
module flatten_index_gen
    import flatten_stream_pkg::*;
#(
    parameter int             F_IN_D   = 8,
    parameter int             F_IN_WXH = 5,
    parameter int             PIX_W    = 3,
    parameter int             IDX_W    = 7,
    parameter flatten_order_e ORDER    = FLAT_HWC
) (
    input  logic [PIX_W-1:0] pix_cnt,
    input  logic [IDX_W-1:0] chan,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        if (ORDER == FLAT_HWC) begin
            idx = IDX_W'(pix_cnt) * IDX_W'(F_IN_D) + chan;
        end else begin
            idx = chan * IDX_W'(F_IN_WXH) + IDX_W'(pix_cnt);
        end
    end

endmodule

// File: rtl/flatten_stream.sv
// Collects one frame of pixel vectors into a register buffer and presents it as a
// single flattened vector; checks pixel addresses against the internal counter.
//   state | meaning
//   FILL  | accepting pixels, pix_cnt = next pixel slot
//   HOLD  | full vector presented, input stalled until consumer accepts
module flatten_stream
    import flatten_stream_pkg::*;
#(
    parameter int             F_IN_D     = 8,
    parameter int             F_IN_H     = 5,
    parameter int             F_IN_W     = 1,
    parameter flatten_order_e ORDER      = FLAT_HWC,
    parameter int             CHECK_ADDR = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    flatten_stream_if.slave   bus,
    output logic              addr_err_o,
    output logic              busy_o
);

    localparam int F_IN_WXH         = F_IN_H * F_IN_W;
    localparam int FLATTEN_OUT_SIZE = F_IN_WXH * F_IN_D;
    localparam int PIX_W            = cnt_width(F_IN_WXH);
    localparam int IDX_W            = $clog2(FLATTEN_OUT_SIZE) + 1;

    if (F_IN_D < 1 || F_IN_WXH < 1) begin : g_param_chk
        $error("flatten_stream: F_IN_D and F_IN_WXH must both be >= 1");
    end

    flatten_state_e                                          state_q;
    logic [PIX_W-1:0]                                        pix_cnt_q;
    logic                                                    in_ready_q;
    logic                                                    out_valid_q;
    logic                                                    addr_err_q;
    logic [FLATTEN_OUT_SIZE-1:0][FEATURE_MAP_RESOLUTION-1:0] buf_q;
    logic [IDX_W-1:0]                                        idx [F_IN_D];

    logic in_hs;
    logic last_pix;
    logic addr_bad;

    assign in_hs    = bus.feature_in_valid_i & in_ready_q;
    assign last_pix = (pix_cnt_q == PIX_W'(F_IN_WXH - 1));
    assign addr_bad = (bus.feature_in_addr_i != FEATURE_MAP_ADDRWIDE'(pix_cnt_q));

    for (genvar c = 0; c < F_IN_D; c++) begin : g_idx
        flatten_index_gen #(
            .F_IN_D   (F_IN_D),
            .F_IN_WXH (F_IN_WXH),
            .PIX_W    (PIX_W),
            .IDX_W    (IDX_W),
            .ORDER    (ORDER)
        ) u_idx (
            .pix_cnt (pix_cnt_q),
            .chan    (IDX_W'(c)),
            .idx     (idx[c])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FILL;
            pix_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            // A mismatched address only flags; data still lands at pix_cnt.
            if (CHECK_ADDR != 0 && in_hs && addr_bad) begin
                addr_err_q <= 1'b1;
            end
            case (state_q)
                FILL: begin
                    if (in_hs) begin
                        if (last_pix) begin
                            pix_cnt_q   <= '0;
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && bus.flatten_ready_i) begin
                        state_q     <= FILL;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    // Buffer is written only in FILL (ready low in HOLD), so a held vector is never disturbed.
    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            for (int k = 0; k < FLATTEN_OUT_SIZE; k++) begin
                for (int c = 0; c < F_IN_D; c++) begin
                    if (idx[c] == IDX_W'(k)) begin
                        buf_q[k] <= bus.feature_in_data_i[c];
                    end
                end
            end
        end
    end

    assign bus.feature_in_ready_o = in_ready_q;
    assign bus.flatten_valid_o    = out_valid_q;
    assign bus.flatten_data_o     = buf_q;
    assign addr_err_o             = addr_err_q;
    assign busy_o                 = (pix_cnt_q != '0) || (state_q == HOLD);

endmodule
